// File: rtl/motor_pkg.sv
// Shared command-word codes and FSM state type for the motor key command path
// and the downstream PWM/H-bridge driver.
package motor_pkg;

    localparam logic [7:0] STOP     = 8'h00;
    localparam logic [7:0] UP       = 8'h01;
    localparam logic [7:0] DOWN     = 8'h02;
    localparam logic [7:0] LEFT     = 8'h04;
    localparam logic [7:0] RIGHT    = 8'h08;
    localparam int         FAST_BIT = 6;
    localparam logic [7:0] DIR_MASK = 8'h0F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2
    } motor_state_e;

    // Exactly one pressed direction yields its code; none or several mean stop.
    function automatic logic [7:0] encode_dir(input logic [3:0] db);
        logic [7:0] code;
        case (db)
            4'b0001: code = UP;
            4'b0010: code = DOWN;
            4'b0100: code = LEFT;
            4'b1000: code = RIGHT;
            default: code = STOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a saturating debounce counter for one
// asynchronous pushbutton input.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             db_r;
    logic [CNT_W-1:0] cnt_r;

    // Metastability filter for the raw button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Accept the new level on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_r  <= 1'b0;
            cnt_r <= CNT_ZERO;
        end else if (sync2_r == db_r) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r >= CNT_LAST) begin
            db_r  <= sync2_r;
            cnt_r <= CNT_ZERO;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign dout = db_r;

endmodule

// File: rtl/motor_key_cmd.sv
// Pushbutton-to-motor command stage: debounce, direction encode, fast toggle and
// reversal protection. Define MOTOR_KEY_DEADTIME_EN to insert stop cycles on reversal.
module motor_key_cmd
    import motor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int DEADTIME_CYCLES = 50000,
    parameter int CNT_W           = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn,
    output logic [7:0] key_state,
    output logic       fast_led
);

    logic [4:0]   db_s;
    logic [7:0]   req_s;
    logic         fast_next_s;
    logic         fast_prev_r;
    motor_state_e state_r;
    motor_state_e state_next_s;
    logic [7:0]   cur_r;
    logic [7:0]   cur_next_s;
    logic [7:0]   key_next_s;
    logic [7:0]   key_state_r;

`ifdef MOTOR_KEY_DEADTIME_EN
    localparam logic [CNT_W-1:0] DEAD_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DEAD_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEAD_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME_CYCLES - 1);

    logic [CNT_W-1:0] dead_cnt_r;
    logic [CNT_W-1:0] dead_cnt_next_s;
`endif

    for (genvar i = 0; i < 5; i++) begin : g_db
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk (clk),
            .rst (rst),
            .din (btn[i]),
            .dout(db_s[i])
        );
    end

    assign req_s       = encode_dir(db_s[3:0]);
    // The fast flag lives in the output register itself; a held button toggles once.
    assign fast_next_s = key_state_r[FAST_BIT] ^ (db_s[4] & ~fast_prev_r);

    // Next state, latched direction and next command word.
    always_comb begin
        state_next_s = state_r;
        cur_next_s   = cur_r;
`ifdef MOTOR_KEY_DEADTIME_EN
        dead_cnt_next_s = dead_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (req_s != STOP) begin
                    state_next_s = DRIVE;
                    cur_next_s   = req_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRIVE: begin
                if (req_s == cur_r) begin
                    state_next_s = DRIVE;
                end else if (req_s == STOP) begin
                    state_next_s = IDLE;
                end else begin
`ifdef MOTOR_KEY_DEADTIME_EN
                    state_next_s    = DEAD;
                    dead_cnt_next_s = DEAD_ZERO;
`else
                    state_next_s = DRIVE;
                    cur_next_s   = req_s;
`endif
                end
            end
`ifdef MOTOR_KEY_DEADTIME_EN
            DEAD: begin
                // Requests are only looked at on the final deadtime cycle.
                if (dead_cnt_r >= DEAD_LAST) begin
                    if (req_s == STOP) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DRIVE;
                        cur_next_s   = req_s;
                    end
                end else if (dead_cnt_r != DEAD_MAX) begin
                    dead_cnt_next_s = dead_cnt_r + DEAD_ONE;
                end else begin
                    dead_cnt_next_s = dead_cnt_r;
                end
            end
`endif
            default: begin
                state_next_s = IDLE;
                cur_next_s   = STOP;
            end
        endcase

        if (state_next_s == DRIVE) begin
            key_next_s = cur_next_s & DIR_MASK;
        end else begin
            key_next_s = STOP;
        end
        key_next_s[FAST_BIT] = fast_next_s;
    end

    // State, direction, fast-edge history and registered command word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cur_r       <= STOP;
            fast_prev_r <= 1'b0;
            key_state_r <= 8'h00;
`ifdef MOTOR_KEY_DEADTIME_EN
            dead_cnt_r  <= DEAD_ZERO;
`endif
        end else begin
            state_r     <= state_next_s;
            cur_r       <= cur_next_s;
            fast_prev_r <= db_s[4];
            key_state_r <= key_next_s;
`ifdef MOTOR_KEY_DEADTIME_EN
            dead_cnt_r  <= dead_cnt_next_s;
`endif
        end
    end

    assign key_state = key_state_r;
    assign fast_led  = key_state_r[FAST_BIT];

endmodule
